// File: rtl/slowclk_rate_ctrl.sv
// slowclk_rate_ctrl
//   Run/pause/step controller for the board's slow clock. A single counter
//   divides CLOCK down to a one-cycle TICK enable and a 50%-duty SLOWCLK
//   square wave at one of four programmable half-period lengths. Rate
//   changes are queued and only take effect on a tick edge, and pause or
//   single-step never cut a half-period short, so SLOWCLK never produces a
//   runt pulse.
//
// Ports
//   CLOCK     in   1  system clock, all state changes on its rising edge
//   RESETN    in   1  asynchronous active-low reset
//   RATE_SEL  in   2  requested rate index, sampled when RATE_REQ=1
//   RATE_REQ  in   1  one-cycle pulse requesting a rate change
//   PAUSE     in   1  level, 1 = hold, 0 = run
//   STEP      in   1  one-cycle pulse, single tick while paused
//   TICK      out  1  registered one-cycle enable, one per half-period
//   SLOWCLK   out  1  registered square wave, toggles with TICK
//   RATE_ACT  out  2  rate index currently in force
//   PEND      out  1  high while a rate request waits for the next tick
module slowclk_rate_ctrl #(
  parameter int CW   = 27,
  parameter int DIV0 = 134217728,
  parameter int DIV1 = 50000000,
  parameter int DIV2 = 12500000,
  parameter int DIV3 = 2500000
) (
  input  logic       CLOCK,
  input  logic       RESETN,
  input  logic [1:0] RATE_SEL,
  input  logic       RATE_REQ,
  input  logic       PAUSE,
  input  logic       STEP,
  output logic       TICK,
  output logic       SLOWCLK,
  output logic [1:0] RATE_ACT,
  output logic       PEND
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    PAUSED   = 2'd1,
    STEPPING = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_last;
  logic [1:0]    pend_idx;
  logic          step_tick;
  logic          advance;
  logic          tick_now;

  // Terminal count for the rate currently in force. Only the active rate
  // matters because a pending rate is swapped in exactly when cnt returns
  // to zero, so cnt can never sit beyond the terminal of a shorter divisor.
  always_comb begin
    cnt_last = CW'(DIV0 - 1);
    case (RATE_ACT)
      2'd0:    cnt_last = CW'(DIV0 - 1);
      2'd1:    cnt_last = CW'(DIV1 - 1);
      2'd2:    cnt_last = CW'(DIV2 - 1);
      2'd3:    cnt_last = CW'(DIV3 - 1);
      default: cnt_last = CW'(DIV0 - 1);
    endcase
  end

  // Next-state and tick decision. PAUSE acts on the very edge it is seen,
  // so a pause landing on the terminal count suppresses that tick and the
  // count holds. A STEP seen while PAUSED wins over a simultaneous PAUSE
  // release. STEPPING behaves like RUN for counting, which gives the step
  // a full half-period before the next run tick if PAUSE has dropped.
  always_comb begin
    state_next = state;
    step_tick  = 1'b0;
    case (state)
      RUN: begin
        if (PAUSE) state_next = PAUSED;
      end
      PAUSED: begin
        if (STEP) begin
          state_next = STEPPING;
          step_tick  = 1'b1;
        end else if (!PAUSE) begin
          state_next = RUN;
        end
      end
      STEPPING: begin
        state_next = PAUSE ? PAUSED : RUN;
      end
      default: state_next = RUN;
    endcase
    advance  = !step_tick && !PAUSE;
    tick_now = step_tick || (advance && (cnt == cnt_last));
  end

  // State, counter and outputs. A new request on a tick edge overrides the
  // PEND clear, so the request lands in the pending slot for the next tick
  // while the tick itself consumes the previously pending index.
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= RUN;
      cnt      <= '0;
      TICK     <= 1'b0;
      SLOWCLK  <= 1'b0;
      RATE_ACT <= 2'd0;
      PEND     <= 1'b0;
      pend_idx <= 2'd0;
    end else begin
      state <= state_next;
      TICK  <= tick_now;
      if (tick_now) begin
        cnt     <= '0;
        SLOWCLK <= ~SLOWCLK;
        if (PEND) begin
          RATE_ACT <= pend_idx;
          PEND     <= 1'b0;
        end
      end else if (advance) begin
        cnt <= cnt + CW'(1);
      end
      if (RATE_REQ) begin
        pend_idx <= RATE_SEL;
        PEND     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slowclk_rate_ctrl.sv
// tb_slowclk_rate_ctrl
//   Self-checking bench for slowclk_rate_ctrl with short divisors
//   (4, 6, 3, 2). Directed scenarios check expected tick edges written out
//   as constants; a randomized run compares every cycle against a
//   behavioural model that tracks elapsed cycles in the current half-period.
module tb_slowclk_rate_ctrl;

  localparam int CW   = 4;
  localparam int DIV0 = 4;
  localparam int DIV1 = 6;
  localparam int DIV2 = 3;
  localparam int DIV3 = 2;

  logic       clock;
  logic       resetn;
  logic [1:0] rate_sel;
  logic       rate_req;
  logic       pause;
  logic       step;
  logic       tick;
  logic       slowclk;
  logic [1:0] rate_act;
  logic       pend;

  int vectors;
  int miscompares;
  int edge_no;

  // Reference model state
  int       div_tab [4];
  int       m_elapsed;
  bit [1:0] m_rate;
  bit [1:0] m_pidx;
  bit       m_pend;
  bit       m_slow;
  bit       m_tick;
  bit       m_can_step;

  slowclk_rate_ctrl #(
    .CW  (CW),
    .DIV0(DIV0),
    .DIV1(DIV1),
    .DIV2(DIV2),
    .DIV3(DIV3)
  ) dut (
    .CLOCK   (clock),
    .RESETN  (resetn),
    .RATE_SEL(rate_sel),
    .RATE_REQ(rate_req),
    .PAUSE   (pause),
    .STEP    (step),
    .TICK    (tick),
    .SLOWCLK (slowclk),
    .RATE_ACT(rate_act),
    .PEND    (pend)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic model_reset();
    m_elapsed  = 0;
    m_rate     = 2'd0;
    m_pidx     = 2'd0;
    m_pend     = 1'b0;
    m_slow     = 1'b0;
    m_tick     = 1'b0;
    m_can_step = 1'b0;
  endtask

  // One edge of the behavioural model: a half-period lasts div cycles of
  // unpaused time; a step is only accepted if the controller was already
  // sitting paused (not on the edge it paused, not right after a step).
  task automatic model_step();
    bit step_now;
    bit adv;
    bit tk;
    step_now = m_can_step && step;
    adv      = !step_now && !pause;
    tk       = step_now || (adv && (m_elapsed == div_tab[m_rate] - 1));
    m_tick   = tk;
    if (tk) begin
      m_slow    = !m_slow;
      m_elapsed = 0;
      if (m_pend) begin
        m_rate = m_pidx;
        m_pend = 1'b0;
      end
    end else if (adv) begin
      m_elapsed = m_elapsed + 1;
    end
    if (rate_req) begin
      m_pidx = rate_sel;
      m_pend = 1'b1;
    end
    m_can_step = pause && !step_now;
  endtask

  // Advance one clock: update model with the inputs in force, then sample
  // 1 time unit after the rising edge.
  task automatic step_clk();
    model_step();
    @(posedge clock);
    #1;
    edge_no = edge_no + 1;
  endtask

  task automatic do_reset();
    rate_sel = 2'd0;
    rate_req = 1'b0;
    pause    = 1'b0;
    step     = 1'b0;
    resetn   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    model_reset();
    resetn  = 1'b1;
    edge_no = 0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    do_reset();
    obs = {tick, slowclk, rate_act, pend};
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_init: got %b expected %b", obs, 5'b0);
    end
    for (int e = 1; e <= 6; e++) step_clk();
    // slowclk is high after edge 4; pull reset away from any clock edge
    #2 resetn = 1'b0;
    #1;
    obs = {tick, slowclk, rate_act, pend};
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got %b expected %b", obs, 5'b0);
    end
    do_reset();
  endtask

  task automatic test_free_run();
    logic [4:0] obs;
    logic [4:0] exp_v;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      step_clk();
      exp_v = {(e % 4) == 0, ((e / 4) % 2) == 1, 2'd0, 1'b0};
      obs   = {tick, slowclk, rate_act, pend};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL free_run edge %0d: got %b expected %b", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_rate_change();
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic       exp_tick;
    logic       exp_slow;
    do_reset();
    exp_slow = 1'b0;
    for (int e = 1; e <= 26; e++) begin
      rate_req = (e == 6);
      rate_sel = 2'd1;
      step_clk();
      exp_tick = (e == 4) || (e == 8) || (e == 14) || (e == 20) || (e == 26);
      if (exp_tick) exp_slow = ~exp_slow;
      exp_v = {exp_tick, exp_slow, (e >= 8) ? 2'd1 : 2'd0, (e == 6) || (e == 7)};
      obs   = {tick, slowclk, rate_act, pend};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL rate_change edge %0d: got %b expected %b", e, obs, exp_v);
      end
    end
    rate_req = 1'b0;
  endtask

  task automatic test_last_wins();
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic       exp_tick;
    logic       exp_slow;
    do_reset();
    exp_slow = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      rate_req = (e == 5) || (e == 7);
      rate_sel = (e == 5) ? 2'd2 : 2'd3;
      step_clk();
      exp_tick = (e == 4) || (e == 8) || (e == 10) || (e == 12) || (e == 14);
      if (exp_tick) exp_slow = ~exp_slow;
      exp_v = {exp_tick, exp_slow, (e >= 8) ? 2'd3 : 2'd0, (e >= 5) && (e <= 7)};
      obs   = {tick, slowclk, rate_act, pend};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL last_wins edge %0d: got %b expected %b", e, obs, exp_v);
      end
    end
    rate_req = 1'b0;
  endtask

  task automatic test_pause();
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic       exp_tick;
    logic       exp_slow;
    do_reset();
    exp_slow = 1'b0;
    for (int e = 1; e <= 18; e++) begin
      pause = (e >= 4) && (e <= 13);
      step_clk();
      exp_tick = (e == 14) || (e == 18);
      if (exp_tick) exp_slow = ~exp_slow;
      exp_v = {exp_tick, exp_slow, 2'd0, 1'b0};
      obs   = {tick, slowclk, rate_act, pend};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL pause edge %0d: got %b expected %b", e, obs, exp_v);
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_step();
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic       exp_tick;
    logic       exp_slow;
    do_reset();
    exp_slow = 1'b0;
    for (int e = 1; e <= 47; e++) begin
      pause = (e <= 40);
      step  = (e == 31) || (e == 36) || (e == 42);
      step_clk();
      exp_tick = (e == 31) || (e == 36) || (e == 44);
      if (exp_tick) exp_slow = ~exp_slow;
      exp_v = {exp_tick, exp_slow, 2'd0, 1'b0};
      obs   = {tick, slowclk, rate_act, pend};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL step edge %0d: got %b expected %b", e, obs, exp_v);
      end
    end
    pause = 1'b0;
    step  = 1'b0;
  endtask

  task automatic test_step_release();
    logic [4:0] obs;
    logic [4:0] exp_v;
    logic       exp_tick;
    logic       exp_slow;
    do_reset();
    exp_slow = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      pause = (e <= 5);
      step  = (e == 6);
      step_clk();
      exp_tick = (e == 6) || (e == 10) || (e == 14);
      if (exp_tick) exp_slow = ~exp_slow;
      exp_v = {exp_tick, exp_slow, 2'd0, 1'b0};
      obs   = {tick, slowclk, rate_act, pend};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL step_release edge %0d: got %b expected %b", e, obs, exp_v);
      end
    end
    step = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    logic [4:0] exp_v;
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      rate_req = (e == 1) || (e == 5);
      rate_sel = (e == 1) ? 2'd2 : 2'd3;
      pause    = (e >= 5);
      step_clk();
      if (e < 4)      exp_v = {1'b0, 1'b0, 2'd0, 1'b1};
      else if (e == 4) exp_v = {1'b1, 1'b1, 2'd2, 1'b0};
      else            exp_v = {1'b0, 1'b1, 2'd2, 1'b1};
      obs = {tick, slowclk, rate_act, pend};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_setup edge %0d: got %b expected %b", e, obs, exp_v);
      end
    end
    rate_req = 1'b0;
    #2 resetn = 1'b0;
    #1;
    obs = {tick, slowclk, rate_act, pend};
    vectors++;
    if (obs !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_async: got %b expected %b", obs, 5'b0);
    end
    pause = 1'b0;
    @(posedge clock);
    @(negedge clock);
    model_reset();
    resetn  = 1'b1;
    edge_no = 0;
    for (int e = 1; e <= 4; e++) begin
      step_clk();
      exp_v = {e == 4, e == 4, 2'd0, 1'b0};
      obs   = {tick, slowclk, rate_act, pend};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_after edge %0d: got %b expected %b", e, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [4:0] obs;
    logic [4:0] exp_v;
    do_reset();
    for (int e = 1; e <= 600; e++) begin
      if ($urandom_range(11) == 0) pause = ~pause;
      step     = ($urandom_range(4) == 0);
      rate_req = ($urandom_range(5) == 0);
      rate_sel = 2'($urandom_range(3));
      step_clk();
      exp_v = {m_tick, m_slow, m_rate, m_pend};
      obs   = {tick, slowclk, rate_act, pend};
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("[TB] FAIL random edge %0d: got %b expected %b", e, obs, exp_v);
      end
    end
    pause    = 1'b0;
    step     = 1'b0;
    rate_req = 1'b0;
  endtask

  initial begin
    div_tab[0]  = DIV0;
    div_tab[1]  = DIV1;
    div_tab[2]  = DIV2;
    div_tab[3]  = DIV3;
    vectors     = 0;
    miscompares = 0;
    edge_no     = 0;
    resetn      = 1'b0;
    rate_sel    = 2'd0;
    rate_req    = 1'b0;
    pause       = 1'b0;
    step        = 1'b0;
    model_reset();
    test_reset();
    test_free_run();
    test_rate_change();
    test_last_wins();
    test_pause();
    test_step();
    test_step_release();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
